cheat_pgm_loader: RTL

//  MCU-side initiator for the cheat engine's programming port. Receives the MCU

---
 rtl/cheat_pgm_loader_pkg.sv | 26 ++
 rtl/cheat_pgm_loader_if.sv | 26 ++
 rtl/cheat_pgm_shadow.sv | 27 ++
 rtl/cheat_pgm_loader.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cheat_pgm_loader_pkg.sv
// Shared encodings for the cheat engine programming loader: FSM states,
// program slot indices and the flag-word bit layout.
package cheat_pgm_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2
  } state_t;

  localparam logic [2:0] PGM_IDX_MASK  = 3'd6;
  localparam logic [2:0] PGM_IDX_FLAGS = 3'd7;
  localparam int         NUM_PATCH     = 6;

  // Word 7: set bits [5:0], reset bits [13:8]
  localparam int FLAG_SET_LSB = 0;
  localparam int FLAG_RST_LSB = 8;
  localparam int FLAG_BITS    = 6;

  function automatic logic [31:0] flag_mask();
    logic [31:0] m;
    m = (32'h3F << FLAG_SET_LSB) | (32'h3F << FLAG_RST_LSB);
    return m;
  endfunction

endpackage

// File: rtl/cheat_pgm_loader_if.sv
// MCU command/data, cheat engine programming and shadow readback signals.
interface cheat_pgm_loader_if;
  logic        cmd_strobe;
  logic        cmd_bulk;
  logic [2:0]  cmd_idx;
  logic        data_strobe;
  logic [7:0]  data_in;
  logic        pgm_blocked;
  logic [2:0]  pgm_idx;
  logic        pgm_we;
  logic [31:0] pgm_in;
  logic        busy;
  logic        err;
  logic [2:0]  rd_idx;
  logic [31:0] rd_data;

  modport master (
    output cmd_strobe, cmd_bulk, cmd_idx, data_strobe, data_in, pgm_blocked, rd_idx,
    input  pgm_idx, pgm_we, pgm_in, busy, err, rd_data
  );

  modport slave (
    input  cmd_strobe, cmd_bulk, cmd_idx, data_strobe, data_in, pgm_blocked, rd_idx,
    output pgm_idx, pgm_we, pgm_in, busy, err, rd_data
  );
endinterface

// File: rtl/cheat_pgm_shadow.sv
// Shadow register file of committed program words: one write port and one
// combinational read port for MCU readback.
module cheat_pgm_shadow #(
  parameter int NUM_SLOTS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [2:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cheat_pgm_loader.sv
// MCU-side initiator for the cheat engine programming port: assembles bytes
// into words, issues writes with retry on pgm_blocked, keeps a shadow copy.
module cheat_pgm_loader
  import cheat_pgm_loader_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd960000,
  parameter int          NUM_SLOTS      = 8
) (
  input logic               clk,
  input logic               rst,
  cheat_pgm_loader_if.slave bus
);

  state_t      state, nxt;
  logic [2:0]  idx_q;
  logic        bulk_q;
  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic [19:0] tmo_q;
  logic        err_q;
  logic        pend_q;
  logic [2:0]  pend_idx_q;
  logic        pend_bulk_q;

  logic        commit;
  logic        timeout;
  logic        restart;
  logic [2:0]  rs_idx;
  logic        rs_bulk;
  logic        last_byte;
  logic        bulk_more;

  always_comb begin
    commit    = (state == ST_ISSUE) && !bus.pgm_blocked;
    timeout   = (state == ST_COLLECT) && !bus.cmd_strobe && !bus.data_strobe &&
                (tmo_q >= (TIMEOUT_CYCLES - 20'd1));
    // A command seen during ISSUE waits for the commit; a fresh one wins over a pending one
    restart   = ((state != ST_ISSUE) && bus.cmd_strobe) ||
                (commit && (bus.cmd_strobe || pend_q));
    rs_idx    = bus.cmd_strobe ? bus.cmd_idx  : pend_idx_q;
    rs_bulk   = bus.cmd_strobe ? bus.cmd_bulk : pend_bulk_q;
    last_byte = bus.data_strobe && (cnt_q == 2'd3);
    bulk_more = bulk_q && (idx_q != PGM_IDX_FLAGS);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (restart) begin
      nxt = ST_COLLECT;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (last_byte)    nxt = ST_COLLECT == ST_COLLECT ? ST_ISSUE : ST_ISSUE;
          else if (timeout) nxt = ST_IDLE;
        end
        ST_ISSUE: begin
          if (commit) nxt = bulk_more ? ST_COLLECT : ST_IDLE;
        end
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      bulk_q      <= 1'b0;
      cnt_q       <= '0;
      word_q      <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      pend_bulk_q <= 1'b0;
    end else begin
      if (restart) begin
        idx_q  <= rs_idx;
        bulk_q <= rs_bulk;
        cnt_q  <= '0;
        word_q <= '0;
        tmo_q  <= '0;
        pend_q <= 1'b0;
      end else begin
        case (state)
          ST_COLLECT: begin
            if (bus.data_strobe) begin
              word_q <= {word_q[23:0], bus.data_in};
              cnt_q  <= cnt_q + 2'd1;
              tmo_q  <= '0;
            end else if (tmo_q != 20'hFFFFF) begin
              tmo_q <= tmo_q + 20'd1;
            end
          end
          ST_ISSUE: begin
            if (bus.cmd_strobe) begin
              pend_q      <= 1'b1;
              pend_idx_q  <= bus.cmd_idx;
              pend_bulk_q <= bus.cmd_bulk;
            end
            if (commit && bulk_more) begin
              idx_q  <= idx_q + 3'd1;
              cnt_q  <= '0;
              word_q <= '0;
              tmo_q  <= '0;
            end
          end
          default: ;
        endcase
      end

      // Dropped bytes and timeouts win over a clearing command in the same cycle
      if ((bus.data_strobe && (state == ST_ISSUE)) ||
          (bus.data_strobe && (state == ST_IDLE) && !bus.cmd_strobe) ||
          timeout)
        err_q <= 1'b1;
      else if (bus.cmd_strobe)
        err_q <= 1'b0;
    end
  end

  cheat_pgm_shadow #(.NUM_SLOTS(NUM_SLOTS)) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .we    (commit),
    .waddr (idx_q),
    .wdata (word_q),
    .raddr (bus.rd_idx),
    .rdata (bus.rd_data)
  );

  assign bus.pgm_we  = (state == ST_ISSUE);
  assign bus.pgm_idx = idx_q;
  assign bus.pgm_in  = word_q;
  assign bus.busy    = (state == ST_ISSUE);
  assign bus.err     = err_q;

endmodule
